// File: rtl/dma_endpoint_pkg.sv
// DMA I/O endpoint shared types.
// FSM encoding and transfer direction codes.
package dma_endpoint_pkg;

  typedef enum logic [5:0] {
    S_IDLE = 6'b000001,
    S_ARM  = 6'b000010,
    S_ACK  = 6'b000100,
    S_XFER = 6'b001000,
    S_HOLD = 6'b010000,
    S_DONE = 6'b100000
  } state_e;

  localparam logic DIR_SOURCE = 1'b1;
  localparam logic DIR_SINK   = 1'b0;

endpackage

// File: rtl/dma_endpoint_fifo.sv
// First-word-fall-through FIFO for the DMA endpoint.
// Pop is evaluated before push, so full push+pop is legal.
module dma_endpoint_fifo #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [DATA_W-1:0]        wdata_i,
  input  logic                     pop_i,
  output logic [DATA_W-1:0]        head_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_q, rd_q;
  logic [AW:0]       cnt_q, cnt_d;
  logic              do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign count_o = cnt_q;
  assign head_o  = mem_q[rd_q];

  // No bypass: a pop on an empty FIFO is dropped.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    cnt_d = cnt_q;
    if (do_push & ~do_pop) cnt_d = cnt_q + (AW+1)'(1);
    if (do_pop & ~do_push) cnt_d = cnt_q - (AW+1)'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= wdata_i;
  end

endmodule

// File: rtl/dma_io_endpoint.sv
// Device-side DMA endpoint: DREQ/DACK handshake, IOR_N/IOW_N
// strobes and EOP_N termination, buffered by a local FIFO.
module dma_io_endpoint
  import dma_endpoint_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              start,
  input  logic              xferDir,
  input  logic              singleMode,
  output logic              DREQ,
  input  logic              DACK,
  input  logic              IOR_N,
  input  logic              IOW_N,
  input  logic              EOP_N,
  input  logic [DATA_W-1:0] DB_in,
  output logic [DATA_W-1:0] DB_out,
  output logic              DB_oe,
  input  logic              pushValid,
  input  logic [DATA_W-1:0] pushData,
  output logic              pushReady,
  output logic              popValid,
  output logic [DATA_W-1:0] popData,
  input  logic              popReady,
  output logic [CNT_W-1:0]  transferCount,
  output logic              done,
  output logic              error
);

  localparam int CW = $clog2(DEPTH) + 1;

  state_e            st_q, st_d;
  logic              dir_q, dir_d, sgl_q, sgl_d;
  logic              eop_q, eop_d, done_q, done_d;
  logic              err_q, err_d, strb_q;
  logic [DATA_W-1:0] cap_q, cap_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              f_push, f_pop, f_full, f_empty;
  logic [DATA_W-1:0] f_wdata, f_head;
  logic [CW-1:0]     f_count;

  logic strb, active, xfer_done, req, eop_hit, src;

  assign src       = (dir_q == DIR_SOURCE);
  assign strb      = src ? IOR_N : IOW_N;
  assign active    = (st_q == S_ACK) | (st_q == S_XFER);
  assign xfer_done = (st_q == S_XFER) & ~strb_q & strb;
  assign req       = src ? (f_count != '0)
                         : (f_count != CW'(DEPTH));
  assign eop_hit   = eop_q | (active & ~EOP_N);

  always_comb begin
    st_d   = st_q;
    dir_d  = dir_q;
    sgl_d  = sgl_q;
    eop_d  = eop_hit;
    done_d = done_q;
    err_d  = err_q;
    cnt_d  = cnt_q;
    cap_d  = (active & DACK & ~strb) ? DB_in : cap_q;
    if (xfer_done) begin
      cnt_d = cnt_q + CNT_W'(1);
      if (src ? f_empty : f_full) err_d = 1'b1;
    end
    unique case (st_q)
      S_IDLE: if (start) begin
        st_d   = S_ARM;
        dir_d  = xferDir;
        sgl_d  = singleMode;
        eop_d  = 1'b0;
        done_d = 1'b0;
        err_d  = 1'b0;
        cnt_d  = '0;
      end
      S_ARM: if (DACK) st_d = S_ACK;
      S_ACK: begin
        if (!DACK)      st_d = S_ARM;
        else if (!strb) st_d = S_XFER;
      end
      S_XFER: if (xfer_done) begin
        eop_d = 1'b0;
        if (eop_hit) begin
          st_d   = S_DONE;
          done_d = 1'b1;
        end else if (sgl_q) st_d = S_HOLD;
        else if (DACK)      st_d = S_ACK;
        else                st_d = S_ARM;
      end
      S_HOLD: if (!DACK) st_d = S_ARM;
      S_DONE: if (start) begin
        st_d   = S_ARM;
        eop_d  = 1'b0;
        done_d = 1'b0;
        err_d  = 1'b0;
        cnt_d  = '0;
      end
      default: st_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      st_q   <= S_IDLE;
      dir_q  <= DIR_SINK;
      sgl_q  <= 1'b0;
      eop_q  <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      strb_q <= 1'b1;
      cap_q  <= '0;
      cnt_q  <= '0;
    end else begin
      st_q   <= st_d;
      dir_q  <= dir_d;
      sgl_q  <= sgl_d;
      eop_q  <= eop_d;
      done_q <= done_d;
      err_q  <= err_d;
      strb_q <= strb;
      cap_q  <= cap_d;
      cnt_q  <= cnt_d;
    end
  end

  assign DREQ = ((st_q == S_ARM) | active) & req;
  assign DB_oe = (st_q == S_XFER) & src;
  assign DB_out = (DB_oe & ~f_empty) ? f_head : '0;
  assign pushReady = src & ~f_full & (st_q != S_IDLE);
  assign popValid = ~src & ~f_empty;
  assign popData = f_head;
  assign transferCount = cnt_q;
  assign done = done_q;
  assign error = err_q;

  // Overrun drops the captured byte rather than displacing queued data.
  assign f_push  = src ? (pushValid & pushReady)
                       : (xfer_done & ~f_full);
  assign f_pop   = src ? (xfer_done & ~f_empty)
                       : (popValid & popReady);
  assign f_wdata = src ? pushData : cap_q;

  dma_endpoint_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk_i   (CLK),
    .rst_i   (RESET),
    .push_i  (f_push),
    .wdata_i (f_wdata),
    .pop_i   (f_pop),
    .head_o  (f_head),
    .full_o  (f_full),
    .empty_o (f_empty),
    .count_o (f_count)
  );

endmodule

// File: tb/tb_dma_io_endpoint.sv
// Directed bench for dma_io_endpoint: cycle vector table
// plus hand sequences for underrun, overrun, wrap and reset.
module tb_dma_io_endpoint;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       start = 1'b0, xferDir = 1'b0, singleMode = 1'b0;
  logic       DREQ, DACK = 1'b0;
  logic       IOR_N = 1'b1, IOW_N = 1'b1, EOP_N = 1'b1;
  logic [7:0] DB_in = '0, DB_out;
  logic       DB_oe;
  logic       pushValid = 1'b0, pushReady;
  logic [7:0] pushData = '0;
  logic       popValid, popReady = 1'b0;
  logic [7:0] popData;
  logic [3:0] transferCount;
  logic       done, error;

  int checks = 0;
  int failures = 0;

  dma_io_endpoint #(
    .DEPTH(8), .DATA_W(8), .CNT_W(4)
  ) dut (
    .CLK(CLK), .RESET(RESET), .start(start),
    .xferDir(xferDir), .singleMode(singleMode),
    .DREQ(DREQ), .DACK(DACK), .IOR_N(IOR_N),
    .IOW_N(IOW_N), .EOP_N(EOP_N), .DB_in(DB_in),
    .DB_out(DB_out), .DB_oe(DB_oe),
    .pushValid(pushValid), .pushData(pushData),
    .pushReady(pushReady), .popValid(popValid),
    .popData(popData), .popReady(popReady),
    .transferCount(transferCount),
    .done(done), .error(error)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic rst, st, dir, sgl, dack, iorn, iown, eopn;
    logic [7:0] dbin;
    logic pv;
    logic [7:0] pd;
    logic pr;
  } drv_t;

  typedef struct {
    logic dreq, oe;
    logic [7:0] dbout;
    logic [3:0] cnt;
    logic done, err, prdy, popv;
    logic [7:0] popd;
  } ex_t;

  typedef struct { drv_t d; ex_t e; } vec_t;

  vec_t tab[$];

  function automatic drv_t dv(
    logic rst, logic st, logic dir, logic sgl,
    logic dack, logic iorn, logic iown, logic eopn,
    logic [7:0] dbin, logic pv, logic [7:0] pd,
    logic pr);
    drv_t r;
    r = '{rst, st, dir, sgl, dack, iorn, iown, eopn,
          dbin, pv, pd, pr};
    return r;
  endfunction

  function automatic ex_t ev(
    logic dreq, logic oe, logic [7:0] dbout,
    logic [3:0] cnt, logic dn, logic err,
    logic prdy, logic popv, logic [7:0] popd);
    ex_t r;
    r = '{dreq, oe, dbout, cnt, dn, err, prdy, popv, popd};
    return r;
  endfunction

  task automatic chk(string nm, logic [15:0] got,
                     logic [15:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", nm, got, want);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic idle();
    RESET = 0; start = 0; DACK = 0;
    IOR_N = 1; IOW_N = 1; EOP_N = 1;
    DB_in = 0; pushValid = 0; pushData = 0;
    popReady = 0;
  endtask

  task automatic do_reset();
    idle();
    RESET = 1;
    cyc();
    RESET = 0;
  endtask

  task automatic go(logic dir, logic sgl);
    start = 1; xferDir = dir; singleMode = sgl;
    cyc();
    start = 0;
  endtask

  task automatic add(drv_t d, ex_t e);
    tab.push_back('{d, e});
  endtask

  initial begin
    string n;
    @(negedge CLK);

    // source, demand mode
    add(dv(1,0,0,0,0,1,1,1,8'h00,0,8'h00,0), ev(0,0,8'h00,0,0,0,0,0,8'h00));
    add(dv(0,1,1,0,0,1,1,1,8'h00,0,8'h00,0), ev(0,0,8'h00,0,0,0,1,0,8'h00));
    add(dv(0,0,0,0,0,1,1,1,8'h00,1,8'h11,0), ev(1,0,8'h00,0,0,0,1,0,8'h00));
    add(dv(0,0,0,0,0,1,1,1,8'h00,1,8'h22,0), ev(1,0,8'h00,0,0,0,1,0,8'h00));
    add(dv(0,0,0,0,0,1,1,1,8'h00,1,8'h33,0), ev(1,0,8'h00,0,0,0,1,0,8'h00));
    add(dv(0,0,0,0,1,1,1,1,8'h00,0,8'h00,0), ev(1,0,8'h00,0,0,0,1,0,8'h00));
    add(dv(0,0,0,0,1,0,1,1,8'h00,0,8'h00,0), ev(1,1,8'h11,0,0,0,1,0,8'h00));
    add(dv(0,0,0,0,1,0,1,1,8'h00,0,8'h00,0), ev(1,1,8'h11,0,0,0,1,0,8'h00));
    add(dv(0,0,0,0,1,1,1,1,8'h00,0,8'h00,0), ev(1,0,8'h00,1,0,0,1,0,8'h00));
    add(dv(0,0,0,0,1,0,1,1,8'h00,0,8'h00,0), ev(1,1,8'h22,1,0,0,1,0,8'h00));
    add(dv(0,0,0,0,1,1,1,1,8'h00,0,8'h00,0), ev(1,0,8'h00,2,0,0,1,0,8'h00));
    add(dv(0,0,0,0,1,0,1,1,8'h00,0,8'h00,0), ev(1,1,8'h33,2,0,0,1,0,8'h00));
    add(dv(0,0,0,0,1,1,1,1,8'h00,0,8'h00,0), ev(0,0,8'h00,3,0,0,1,0,8'h00));
    add(dv(0,0,0,0,0,1,1,1,8'h00,0,8'h00,0), ev(0,0,8'h00,3,0,0,1,0,8'h00));
    // sink, single mode
    add(dv(1,0,0,0,0,1,1,1,8'h00,0,8'h00,0), ev(0,0,8'h00,0,0,0,0,0,8'h00));
    add(dv(0,1,0,1,0,1,1,1,8'h00,0,8'h00,0), ev(1,0,8'h00,0,0,0,0,0,8'h00));
    add(dv(0,0,0,0,1,1,1,1,8'h00,0,8'h00,0), ev(1,0,8'h00,0,0,0,0,0,8'h00));
    add(dv(0,0,0,0,1,1,0,1,8'hA5,0,8'h00,0), ev(1,0,8'h00,0,0,0,0,0,8'h00));
    add(dv(0,0,0,0,1,1,1,1,8'h00,0,8'h00,0), ev(0,0,8'h00,1,0,0,0,1,8'hA5));
    add(dv(0,0,0,0,1,1,1,1,8'h00,0,8'h00,0), ev(0,0,8'h00,1,0,0,0,1,8'hA5));
    add(dv(0,0,0,0,0,1,1,1,8'h00,0,8'h00,0), ev(1,0,8'h00,1,0,0,0,1,8'hA5));
    add(dv(0,0,0,0,1,1,1,1,8'h00,0,8'h00,0), ev(1,0,8'h00,1,0,0,0,1,8'hA5));
    add(dv(0,0,0,0,1,1,0,1,8'h5A,0,8'h00,0), ev(1,0,8'h00,1,0,0,0,1,8'hA5));
    add(dv(0,0,0,0,1,1,1,1,8'h00,0,8'h00,0), ev(0,0,8'h00,2,0,0,0,1,8'hA5));
    add(dv(0,0,0,0,0,1,1,1,8'h00,0,8'h00,1), ev(1,0,8'h00,2,0,0,0,1,8'h5A));
    add(dv(0,0,0,0,0,1,1,1,8'h00,0,8'h00,1), ev(1,0,8'h00,2,0,0,0,0,8'h00));
    // EOP on the second of four source bytes
    add(dv(1,0,0,0,0,1,1,1,8'h00,0,8'h00,0), ev(0,0,8'h00,0,0,0,0,0,8'h00));
    add(dv(0,1,1,0,0,1,1,1,8'h00,0,8'h00,0), ev(0,0,8'h00,0,0,0,1,0,8'h00));
    add(dv(0,0,1,0,0,1,1,1,8'h00,1,8'h01,0), ev(1,0,8'h00,0,0,0,1,0,8'h00));
    add(dv(0,0,1,0,0,1,1,1,8'h00,1,8'h02,0), ev(1,0,8'h00,0,0,0,1,0,8'h00));
    add(dv(0,0,1,0,0,1,1,1,8'h00,1,8'h03,0), ev(1,0,8'h00,0,0,0,1,0,8'h00));
    add(dv(0,0,1,0,0,1,1,1,8'h00,1,8'h04,0), ev(1,0,8'h00,0,0,0,1,0,8'h00));
    add(dv(0,0,1,0,1,1,1,1,8'h00,0,8'h00,0), ev(1,0,8'h00,0,0,0,1,0,8'h00));
    add(dv(0,0,1,0,1,0,1,1,8'h00,0,8'h00,0), ev(1,1,8'h01,0,0,0,1,0,8'h00));
    add(dv(0,0,1,0,1,1,1,1,8'h00,0,8'h00,0), ev(1,0,8'h00,1,0,0,1,0,8'h00));
    add(dv(0,0,1,0,1,0,1,0,8'h00,0,8'h00,0), ev(1,1,8'h02,1,0,0,1,0,8'h00));
    add(dv(0,0,1,0,1,1,1,1,8'h00,0,8'h00,0), ev(0,0,8'h00,2,1,0,1,0,8'h00));
    add(dv(0,0,1,0,0,1,1,1,8'h00,0,8'h00,0), ev(0,0,8'h00,2,1,0,1,0,8'h00));
    add(dv(0,1,1,0,0,1,1,1,8'h00,0,8'h00,0), ev(1,0,8'h00,0,0,0,1,0,8'h00));
    add(dv(0,0,1,0,1,1,1,1,8'h00,0,8'h00,0), ev(1,0,8'h00,0,0,0,1,0,8'h00));
    add(dv(0,0,1,0,1,0,1,1,8'h00,0,8'h00,0), ev(1,1,8'h03,0,0,0,1,0,8'h00));
    add(dv(0,0,1,0,1,1,1,1,8'h00,0,8'h00,0), ev(1,0,8'h00,1,0,0,1,0,8'h00));
    add(dv(0,0,1,0,1,0,1,1,8'h00,0,8'h00,0), ev(1,1,8'h04,1,0,0,1,0,8'h00));
    add(dv(0,0,1,0,1,1,1,1,8'h00,0,8'h00,0), ev(0,0,8'h00,2,0,0,1,0,8'h00));

    foreach (tab[i]) begin
      RESET = tab[i].d.rst; start = tab[i].d.st;
      xferDir = tab[i].d.dir; singleMode = tab[i].d.sgl;
      DACK = tab[i].d.dack; IOR_N = tab[i].d.iorn;
      IOW_N = tab[i].d.iown; EOP_N = tab[i].d.eopn;
      DB_in = tab[i].d.dbin; pushValid = tab[i].d.pv;
      pushData = tab[i].d.pd; popReady = tab[i].d.pr;
      cyc();
      n = $sformatf("r%0d", i);
      chk({n, "_dreq"}, 16'(DREQ), 16'(tab[i].e.dreq));
      chk({n, "_oe"}, 16'(DB_oe), 16'(tab[i].e.oe));
      chk({n, "_db"}, 16'(DB_out), 16'(tab[i].e.dbout));
      chk({n, "_cnt"}, 16'(transferCount), 16'(tab[i].e.cnt));
      chk({n, "_done"}, 16'(done), 16'(tab[i].e.done));
      chk({n, "_err"}, 16'(error), 16'(tab[i].e.err));
      chk({n, "_prdy"}, 16'(pushReady), 16'(tab[i].e.prdy));
      chk({n, "_popv"}, 16'(popValid), 16'(tab[i].e.popv));
      if (tab[i].e.popv)
        chk({n, "_popd"}, 16'(popData), 16'(tab[i].e.popd));
    end

    // underrun: strobe against an empty source FIFO
    do_reset();
    go(1, 0);
    DACK = 1; cyc();
    IOR_N = 0; cyc();
    chk("ur_oe", 16'(DB_oe), 16'd1);
    chk("ur_db", 16'(DB_out), 16'h00);
    IOR_N = 1; cyc();
    chk("ur_err", 16'(error), 16'd1);
    chk("ur_cnt", 16'(transferCount), 16'd1);
    chk("ur_dreq", 16'(DREQ), 16'd0);
    DACK = 0; cyc();
    pushValid = 1; pushData = 8'h77; cyc();
    pushValid = 0;
    chk("ur_dreq2", 16'(DREQ), 16'd1);
    DACK = 1; cyc();
    IOR_N = 0; cyc();
    chk("ur_db2", 16'(DB_out), 16'h77);
    IOR_N = 1; DACK = 0; cyc();
    chk("ur_cnt2", 16'(transferCount), 16'd2);
    chk("ur_empty", 16'(DREQ), 16'd0);

    // overrun: nine sink strobes into an 8-deep FIFO
    do_reset();
    go(0, 0);
    DACK = 1; cyc();
    for (int i = 0; i < 9; i++) begin
      IOW_N = 0; DB_in = 8'(i + 1); cyc();
      IOW_N = 1; DB_in = 0; cyc();
      if (i == 7) begin
        chk("or_err8", 16'(error), 16'd0);
        chk("or_full", 16'(DREQ), 16'd0);
      end
    end
    chk("or_err", 16'(error), 16'd1);
    chk("or_cnt", 16'(transferCount), 16'd9);
    DACK = 0; cyc();
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("or_pv%0d", i), 16'(popValid), 16'd1);
      chk($sformatf("or_pd%0d", i), 16'(popData), 16'(i + 1));
      popReady = 1; cyc();
      popReady = 0;
    end
    chk("or_drained", 16'(popValid), 16'd0);

    // counter wrap at 4 bits: 17 transfers leave 1
    do_reset();
    go(0, 0);
    DACK = 1; popReady = 1; cyc();
    for (int i = 0; i < 17; i++) begin
      IOW_N = 0; DB_in = 8'(i); cyc();
      IOW_N = 1; cyc();
    end
    chk("wr_cnt", 16'(transferCount), 16'd1);
    chk("wr_err", 16'(error), 16'd0);

    // reset while the read strobe is low
    do_reset();
    go(1, 0);
    pushValid = 1; pushData = 8'hAA; cyc();
    pushValid = 0;
    DACK = 1; cyc();
    IOR_N = 0; cyc();
    chk("rs_oe1", 16'(DB_oe), 16'd1);
    chk("rs_db1", 16'(DB_out), 16'hAA);
    RESET = 1; cyc();
    chk("rs_oe", 16'(DB_oe), 16'd0);
    chk("rs_dreq", 16'(DREQ), 16'd0);
    chk("rs_cnt", 16'(transferCount), 16'd0);
    chk("rs_prdy", 16'(pushReady), 16'd0);
    chk("rs_db", 16'(DB_out), 16'h00);
    RESET = 0; IOR_N = 1; cyc();
    chk("rs_cnt2", 16'(transferCount), 16'd0);
    DACK = 0;
    go(1, 0);
    chk("rs_empty", 16'(DREQ), 16'd0);
    chk("rs_err", 16'(error), 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
